mmio_host_port: RTL and testbench
=================================

MMIO_HOST_PORT -- requirements
Module: mmio_host_port

Interface
REQ-001 Parameter CONSOLE_ADDR, default 32'h0000_0400, byte address of the console data register.
REQ-002 Parameter EXIT_ADDR, default 32'h0000_0404, byte address of the exit/halt register.
REQ-003 Parameter FIFO_DEPTH, default 8, console FIFO entries; power of two, minimum 2.
REQ-004 Parameter TIMEOUT_CYCLES, default 1000, run-cycle limit before timeout; minimum 1.
REQ-005 clk  input  1  rising-edge clock; the block's single clock.
REQ-006 resetn  input  1  reset; asynchronous, active-low.
REQ-007 mem_wr_en  input  1  CPU store strobe, same net that drives data memory.
REQ-008 mem_addr  input  32  CPU data address.
REQ-009 mem_data_in  input  32  CPU store data.
REQ-010 char_valid  output  1  console FIFO head valid.
REQ-011 char_data  output  8  console FIFO head byte.
REQ-012 char_ready  input  1  sink accepts the head byte.
REQ-013 halted  output  1  program wrote EXIT_ADDR.
REQ-014 timed_out  output  1  TIMEOUT_CYCLES elapsed without halt.
REQ-015 exit_code  output  32  word stored to EXIT_ADDR.
REQ-016 cycle_count  output  32  cycles spent in RUN.
REQ-017 overflow  output  1  sticky; a console store was dropped because FIFO was full.

Function
REQ-018 Store hit: mem_wr_en=1 and mem_addr exactly equals CONSOLE_ADDR or EXIT_ADDR, sampled at rising clk edge; no other address has any effect.
REQ-019 State machine: RUN, HALTED, TIMEOUT; RUN entered on reset release.
REQ-020 RUN -> HALTED on EXIT_ADDR hit; exit_code <= mem_data_in on that same edge; halted=1 from the next cycle.
REQ-021 RUN -> TIMEOUT on the edge where cycle_count equals TIMEOUT_CYCLES-1 and there is no EXIT_ADDR hit; timed_out=1 from the next cycle.
REQ-022 EXIT_ADDR hit on the timeout edge: HALTED wins.
REQ-023 HALTED and TIMEOUT are terminal until reset; stores in these states are ignored, including console stores.
REQ-024 cycle_count increments by 1 on every edge in RUN, including the exiting edge; it freezes in HALTED/TIMEOUT and does not wrap below TIMEOUT_CYCLES.
REQ-025 CONSOLE_ADDR hit in RUN pushes mem_data_in[7:0]; bits [31:8] are discarded.
REQ-026 FIFO output: char_valid = not empty; char_data = head entry, combinational from storage.
REQ-027 Pop on edge with char_valid=1 and char_ready=1; char_ready while empty has no effect.
REQ-028 Push while full and no pop in the same cycle: byte dropped, overflow set, FIFO contents unchanged.
REQ-029 Push and pop in the same cycle while full: both succeed, occupancy unchanged, overflow not set.
REQ-030 Push and pop in the same cycle while empty: push only; the byte becomes visible the next cycle (no bypass).
REQ-031 Read/write pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit or count.
REQ-032 The FIFO continues draining in HALTED/TIMEOUT, so buffered bytes are not lost after exit.

Reset
REQ-033 resetn=0 asynchronously forces: state RUN, cycle_count 0, exit_code 0, halted 0, timed_out 0, overflow 0, FIFO empty (char_valid 0), char_data 0.
REQ-034 Reset asserted mid-operation discards all FIFO contents and the terminal state; counting restarts from 0 on the first edge after release.

Verification
REQ-035 Store 0x0000_0041 to CONSOLE_ADDR with char_ready=1 -> char_valid=1, char_data=0x41 the next cycle; pop on the following edge; FIFO empty after.
REQ-036 With char_ready=0, push 9 bytes 0x01..0x09 at DEPTH 8 -> overflow=1; draining yields 0x01..0x08 in order, then char_valid=0.
REQ-037 Store 0x0000_0069 to EXIT_ADDR at cycle 40 -> halted=1, exit_code=0x69, cycle_count frozen at 41; a later console store is ignored.
REQ-038 No exit store, TIMEOUT_CYCLES=1000 -> timed_out=1 and cycle_count=1000 after 1000 cycles; halted stays 0.
REQ-039 Full FIFO with simultaneous push and pop -> occupancy stays 8, overflow stays 0; EXIT hit on the timeout edge -> halted=1, timed_out=0.
REQ-040 Assert resetn=0 between clock edges while in HALTED with 3 bytes queued -> all outputs 0 immediately, without waiting for a clock edge; RUN resumes after release.

Source files
------------

// File: rtl/mmio_host_port.sv
// mmio_host_port
// Watches the CPU data-memory store bus for two magic addresses and turns them
// into host-side services: a byte-wide console stream buffered in a small FIFO,
// and an exit register that ends the run. It also runs a watchdog that ends the
// run after a fixed number of cycles if the program never writes the exit register.
//
// State table (FSM in the second always_ff below):
//   state      | meaning
//   ST_RUN     | program executing; stores are decoded, cycle_count advances
//   ST_HALTED  | program wrote EXIT_ADDR; terminal until reset
//   ST_TIMEOUT | TIMEOUT_CYCLES elapsed with no exit; terminal until reset
//
// Ports
//   clk          in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   mem_wr_en    in   CPU store strobe
//   mem_addr     in   CPU store byte address
//   mem_data_in  in   CPU store data
//   char_valid   out  console FIFO not empty
//   char_data    out  console FIFO head byte
//   char_ready   in   sink takes the head byte this cycle
//   halted       out  run ended through EXIT_ADDR
//   timed_out    out  run ended through the watchdog
//   exit_code    out  word written to EXIT_ADDR
//   cycle_count  out  edges spent in ST_RUN
//   overflow     out  sticky; a console byte was dropped on a full FIFO
module mmio_host_port #(
    parameter logic [31:0] CONSOLE_ADDR   = 32'h0000_0400,
    parameter logic [31:0] EXIT_ADDR      = 32'h0000_0404,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_wr_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data_in,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        halted,
    output logic        timed_out,
    output logic [31:0] exit_code,
    output logic [31:0] cycle_count,
    output logic        overflow
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [31:0] TC_LAST  = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] cycle_count_q;
    logic [31:0] exit_code_q;
    logic        halted_q;
    logic        timed_out_q;
    logic        overflow_q;

    logic [7:0]  mem_q [FIFO_DEPTH];
    // One extra pointer bit separates full (MSBs differ) from empty (equal).
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    logic in_run;
    logic exit_hit;
    logic cons_hit;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;

    assign in_run     = (state_q == ST_RUN);
    assign exit_hit   = in_run && mem_wr_en && (mem_addr == EXIT_ADDR);
    assign cons_hit   = in_run && mem_wr_en && (mem_addr == CONSOLE_ADDR);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && char_ready;
    // A pop on a full FIFO frees the slot the push lands in; on an empty FIFO
    // pop is already 0, so push-and-pop degenerates to push only.
    assign push       = cons_hit && (!fifo_full || pop);
    assign drop       = cons_hit && fifo_full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) mem_q[wr_ptr_q[AW-1:0]] <= mem_data_in[7:0];
            if (drop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_RUN;
            cycle_count_q <= 32'd0;
            exit_code_q   <= 32'd0;
            halted_q      <= 1'b0;
            timed_out_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    cycle_count_q <= cycle_count_q + 32'd1;
                    // Exit takes priority over the watchdog on the same edge.
                    if (exit_hit) begin
                        state_q     <= ST_HALTED;
                        halted_q    <= 1'b1;
                        exit_code_q <= mem_data_in;
                    end else if (cycle_count_q == TC_LAST) begin
                        state_q     <= ST_TIMEOUT;
                        timed_out_q <= 1'b1;
                    end
                end
                ST_HALTED:  state_q <= ST_HALTED;
                ST_TIMEOUT: state_q <= ST_TIMEOUT;
                default:    state_q <= ST_RUN;
            endcase
        end
    end

    assign char_valid  = !fifo_empty;
    assign char_data   = mem_q[rd_ptr_q[AW-1:0]];
    assign halted      = halted_q;
    assign timed_out   = timed_out_q;
    assign exit_code   = exit_code_q;
    assign cycle_count = cycle_count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_mmio_host_port.sv
// Directed bench for mmio_host_port at default parameters (console 0x400,
// exit 0x404, 8-entry FIFO, 1000-cycle watchdog). Inputs change and outputs
// are sampled 1 ns after the rising edge.
module tb_mmio_host_port;

    localparam logic [31:0] CONS = 32'h0000_0400;
    localparam logic [31:0] EXIT = 32'h0000_0404;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        halted;
    logic        timed_out;
    logic [31:0] exit_code;
    logic [31:0] cycle_count;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mmio_host_port dut (
        .clk         (clk),
        .resetn      (resetn),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .char_ready  (char_ready),
        .halted      (halted),
        .timed_out   (timed_out),
        .exit_code   (exit_code),
        .cycle_count (cycle_count),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        mem_wr_en   = 1'b1;
        mem_addr    = addr;
        mem_data_in = data;
        tick();
        mem_wr_en   = 1'b0;
        mem_addr    = 32'd0;
        mem_data_in = 32'd0;
    endtask

    // Releases reset mid-cycle, so the next rising edge is the first counted one.
    task automatic do_reset();
        mem_wr_en  = 1'b0;
        char_ready = 1'b0;
        resetn     = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        resetn      = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = 32'd0;
        mem_data_in = 32'd0;
        char_ready  = 1'b0;
        tick();
        check("rst_valid",     32'(char_valid),  32'd0);
        check("rst_data",      32'(char_data),   32'd0);
        check("rst_halted",    32'(halted),      32'd0);
        check("rst_timed_out", 32'(timed_out),   32'd0);
        check("rst_overflow",  32'(overflow),    32'd0);
        check("rst_exit_code", exit_code,        32'd0);
        check("rst_count",     cycle_count,      32'd0);
        resetn = 1'b1;

        // Single console byte, address decode, upper bits dropped
        char_ready = 1'b1;
        store(32'h0000_0408, 32'h55);
        check("nohit_408", 32'(char_valid), 32'd0);
        store(32'h0000_0401, 32'h66);
        check("nohit_401", 32'(char_valid), 32'd0);
        store(CONS, 32'h0000_0041);
        check("c41_valid", 32'(char_valid), 32'd1);
        check("c41_data",  32'(char_data),  32'h41);
        tick();
        check("c41_popped", 32'(char_valid), 32'd0);
        store(CONS, 32'hFFFF_FF7E);
        check("c7e_data", 32'(char_data), 32'h7E);
        tick();
        check("c7e_popped", 32'(char_valid), 32'd0);

        // Overflow on the ninth push, ordered drain
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            store(CONS, 32'(i));
            if (i == 8) check("ovf_at_8", 32'(overflow), 32'd0);
        end
        check("ovf_at_9", 32'(overflow), 32'd1);
        char_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain_valid_%0d", i), 32'(char_valid), 32'd1);
            check($sformatf("drain_data_%0d", i),  32'(char_data),  32'(i));
            tick();
        end
        check("drain_empty", 32'(char_valid), 32'd0);
        check("ovf_sticky",  32'(overflow),   32'd1);

        // Push and pop together on a full FIFO
        do_reset();
        for (int i = 0; i < 8; i++) store(CONS, 32'h10 + 32'(i));
        check("full_no_ovf", 32'(overflow), 32'd0);
        char_ready = 1'b1;
        store(CONS, 32'h18);
        check("pp_no_ovf", 32'(overflow),  32'd0);
        check("pp_head",   32'(char_data), 32'h11);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("pp_valid_%0d", i), 32'(char_valid), 32'd1);
            check($sformatf("pp_data_%0d", i),  32'(char_data),  32'h10 + 32'(i));
            tick();
        end
        check("pp_empty", 32'(char_valid), 32'd0);

        // Exit at cycle 40
        do_reset();
        repeat (40) tick();
        check("cnt_40", cycle_count, 32'd40);
        store(EXIT, 32'h0000_0069);
        check("ex_halted",    32'(halted),    32'd1);
        check("ex_code",      exit_code,      32'h69);
        check("ex_count",     cycle_count,    32'd41);
        check("ex_timed_out", 32'(timed_out), 32'd0);
        store(CONS, 32'h33);
        check("ex_cons_ignored", 32'(char_valid), 32'd0);
        check("ex_count_frozen", cycle_count,     32'd41);
        store(EXIT, 32'h70);
        check("ex_code_kept", exit_code, 32'h69);

        // Drain in HALTED, then async reset with 3 bytes queued
        do_reset();
        store(CONS, 32'hA1);
        store(CONS, 32'hA2);
        store(CONS, 32'hA3);
        store(CONS, 32'hA4);
        store(EXIT, 32'h5);
        check("h_halted", 32'(halted), 32'd1);
        check("h_count",  cycle_count, 32'd5);
        check("h_head",   32'(char_data), 32'hA1);
        char_ready = 1'b1;
        tick();
        char_ready = 1'b0;
        check("h_drain_valid", 32'(char_valid), 32'd1);
        check("h_drain_data",  32'(char_data),  32'hA2);
        #2;
        resetn = 1'b0;
        #1;
        check("ar_valid",     32'(char_valid), 32'd0);
        check("ar_data",      32'(char_data),  32'd0);
        check("ar_halted",    32'(halted),     32'd0);
        check("ar_timed_out", 32'(timed_out),  32'd0);
        check("ar_overflow",  32'(overflow),   32'd0);
        check("ar_exit_code", exit_code,       32'd0);
        check("ar_count",     cycle_count,     32'd0);
        tick();
        resetn = 1'b1;
        tick();
        check("rr_count",  cycle_count,  32'd1);
        check("rr_halted", 32'(halted),  32'd0);
        store(CONS, 32'h5A);
        check("rr_valid", 32'(char_valid), 32'd1);
        check("rr_data",  32'(char_data),  32'h5A);
        check("rr_count2", cycle_count,    32'd2);

        // Watchdog timeout with bytes still buffered
        do_reset();
        store(CONS, 32'hC1);
        store(CONS, 32'hC2);
        repeat (997) tick();
        check("to_cnt_999", cycle_count,     32'd999);
        check("to_not_yet", 32'(timed_out),  32'd0);
        tick();
        check("to_flag",   32'(timed_out), 32'd1);
        check("to_count",  cycle_count,    32'd1000);
        check("to_halted", 32'(halted),    32'd0);
        store(EXIT, 32'h1);
        check("to_exit_ignored", 32'(halted), 32'd0);
        check("to_code_zero",    exit_code,   32'd0);
        check("to_count_frozen", cycle_count, 32'd1000);
        store(CONS, 32'hC3);
        char_ready = 1'b1;
        check("to_drain_1", 32'(char_data), 32'hC1);
        tick();
        check("to_drain_2", 32'(char_data), 32'hC2);
        tick();
        check("to_drain_empty", 32'(char_valid), 32'd0);

        // Exit on the timeout edge: HALTED wins
        do_reset();
        repeat (999) tick();
        check("race_cnt_999", cycle_count, 32'd999);
        store(EXIT, 32'h0000_00AB);
        check("race_halted",    32'(halted),    32'd1);
        check("race_timed_out", 32'(timed_out), 32'd0);
        check("race_code",      exit_code,      32'hAB);
        check("race_count",     cycle_count,    32'd1000);
        tick();
        check("race_timed_out2", 32'(timed_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
